nios_system_avalon_st_ready_latency_adapter: RTL and testbench

- Avalon-ST adapter: the sink side uses ready latency 0; the source side uses ready latency READY_LATENCY (1..4).
- It is the inverse of our FIFO-based timing adapter, which absorbs a latency-N upstream into a latency-0 downstream.
- This block feeds latency-N consumers, e.g. video DMA and on-chip FIFO sinks, from latency-0 producers.
- Outputs are fully registered. A packet-framing monitor flags SOP/EOP protocol violations for debug.

---
 rtl/nios_system_avalon_st_pkg.sv | 19 +
 rtl/nios_system_avalon_st_ready_pipe.sv | 37 +++
 rtl/nios_system_avalon_st_ready_latency_adapter.sv | 120 ++++++++++++
 tb/tb_nios_system_avalon_st_ready_latency_adapter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_avalon_st_pkg.sv
// rtl/nios_system_avalon_st_pkg.sv - shared types and constants for the Avalon-ST adapters
package nios_system_avalon_st_pkg;

  // Legal source-side ready latency range.
  localparam int READY_LATENCY_MIN = 1;
  localparam int READY_LATENCY_MAX = 4;

  // Packet framing monitor state.
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  // Packed beat: data, channel, error, SOP and EOP.
  function automatic int payload_width(input int data_w, input int channel_w, input int error_w);
    return data_w + channel_w + error_w + 2;
  endfunction

endpackage

// File: rtl/nios_system_avalon_st_ready_pipe.sv
// rtl/nios_system_avalon_st_ready_pipe.sv - ready-history shift register
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset, clears the history
//   i_ready  ready sampled each cycle
//   o_hist   o_hist[k] holds i_ready from k+1 cycles ago
module nios_system_avalon_st_ready_pipe
  import nios_system_avalon_st_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ready,
  output logic [DEPTH-1:0] o_hist
);

  logic [DEPTH-1:0] r_hist;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= '0;
        else        r_hist <= i_ready;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= '0;
        else        r_hist <= {r_hist[DEPTH-2:0], i_ready};
      end
    end
  endgenerate

  assign o_hist = r_hist;

endmodule

// File: rtl/nios_system_avalon_st_ready_latency_adapter.sv
// rtl/nios_system_avalon_st_ready_latency_adapter.sv - ready latency 0 sink to latency N source adapter
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_*                    Avalon-ST sink, ready latency 0
//   out_*                   Avalon-ST source, ready latency READY_LATENCY, fully registered
//   framing_error           sticky SOP/EOP protocol violation flag
//   clear_error             synchronous clear for framing_error
module nios_system_avalon_st_ready_latency_adapter
  import nios_system_avalon_st_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CHANNEL_W     = 2,
  parameter int ERROR_W       = 6,
  parameter int READY_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [CHANNEL_W-1:0] in_channel,
  input  logic [ERROR_W-1:0]   in_error,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [CHANNEL_W-1:0] out_channel,
  output logic [ERROR_W-1:0]   out_error,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic                 framing_error,
  input  logic                 clear_error
);

  localparam int PAYLOAD_W = payload_width(DATA_W, CHANNEL_W, ERROR_W);

  generate
    if (READY_LATENCY < READY_LATENCY_MIN || READY_LATENCY > READY_LATENCY_MAX) begin : g_bad_latency
      $error("READY_LATENCY must be in the range 1..4");
    end
  endgenerate

  logic [READY_LATENCY-1:0] w_rdy_sr;
  logic                     w_xfer;
  logic [PAYLOAD_W-1:0]     w_in_payload;
  logic                     w_unused_rdy;

  logic                     r_valid;
  logic [PAYLOAD_W-1:0]     r_payload;
  frame_state_e             r_state;
  logic                     r_framing_error;

  nios_system_avalon_st_ready_pipe #(
    .DEPTH (READY_LATENCY)
  ) u_ready_pipe (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_ready (out_ready),
    .o_hist  (w_rdy_sr)
  );

  // Accept a beat now only if the source ready it will be issued against
  // (READY_LATENCY cycles before the issue cycle) was already high; the beat
  // then leaves one cycle later, so no more than one beat is ever held.
  generate
    if (READY_LATENCY == 1) begin : g_rl1
      assign in_ready = out_ready;
    end else begin : g_rln
      assign in_ready = w_rdy_sr[READY_LATENCY-2];
    end
  endgenerate

  // The full history stays visible for debug; only one tap drives in_ready.
  assign w_unused_rdy = ^w_rdy_sr;

  assign w_xfer       = in_valid & in_ready;
  assign w_in_payload = {in_data, in_channel, in_error, in_startofpacket, in_endofpacket};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) r_payload <= w_in_payload;
    end
  end

  assign out_valid = r_valid;
  assign {out_data, out_channel, out_error, out_startofpacket, out_endofpacket} = r_payload;

  // Framing monitor. The violation update comes after the clear so that a
  // violation in the same cycle as clear_error leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_framing_error <= 1'b0;
    end else begin
      if (clear_error) r_framing_error <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          IDLE: begin
            if (!in_startofpacket)    r_framing_error <= 1'b1;
            else if (!in_endofpacket) r_state         <= IN_PKT;
          end
          IN_PKT: begin
            if (in_startofpacket) r_framing_error <= 1'b1;
            if (in_endofpacket)   r_state         <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign framing_error = r_framing_error;

endmodule

// File: tb/tb_nios_system_avalon_st_ready_latency_adapter.sv
// tb/tb_nios_system_avalon_st_ready_latency_adapter.sv - directed self-checking bench for the ready latency adapter
module tb_nios_system_avalon_st_ready_latency_adapter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_channel = '0;
  logic [5:0]  in_error = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        clear_error = 1'b0;

  logic        out_ready1 = 1'b0, out_ready2 = 1'b0, out_ready3 = 1'b0;
  logic        in_ready1, in_ready2, in_ready3;
  logic        out_valid1, out_valid2, out_valid3;
  logic [31:0] out_data1, out_data2, out_data3;
  logic [1:0]  out_channel1, out_channel2, out_channel3;
  logic [5:0]  out_error1, out_error2, out_error3;
  logic        out_sop1, out_sop2, out_sop3;
  logic        out_eop1, out_eop2, out_eop3;
  logic        ferr1, ferr2, ferr3;

  int total = 0;
  int bad = 0;
  logic [9:0] pat;

  always #5 clk = ~clk;

  nios_system_avalon_st_ready_latency_adapter #(.READY_LATENCY(1)) u_rl1 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready1), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_channel(out_channel1),
    .out_error(out_error1), .out_startofpacket(out_sop1), .out_endofpacket(out_eop1),
    .framing_error(ferr1), .clear_error(clear_error)
  );

  nios_system_avalon_st_ready_latency_adapter #(.READY_LATENCY(2)) u_rl2 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready2), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_channel(out_channel2),
    .out_error(out_error2), .out_startofpacket(out_sop2), .out_endofpacket(out_eop2),
    .framing_error(ferr2), .clear_error(clear_error)
  );

  nios_system_avalon_st_ready_latency_adapter #(.READY_LATENCY(3)) u_rl3 (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready3), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_channel(out_channel3),
    .out_error(out_error3), .out_startofpacket(out_sop3), .out_endofpacket(out_eop3),
    .framing_error(ferr3), .clear_error(clear_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_out_valid2", out_valid2, 0);
    chk("rst_ferr2", ferr2, 0);
    chk("rst_in_ready2", in_ready2, 0);
    chk("rst_out_data2", out_data2, 0);
    chk("rst_in_ready3", in_ready3, 0);

    // RL=2 streaming, out_ready held high
    reset_n    = 1'b1;
    out_ready2 = 1'b1;
    chk("rl2_in_ready_before", in_ready2, 0);
    step();
    chk("rl2_in_ready_after", in_ready2, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_sop   = (i == 0);
      in_eop   = (i == 7);
      step();
      chk($sformatf("rl2_valid_%0d", i), out_valid2, 1);
      chk($sformatf("rl2_data_%0d", i), out_data2, 64'(i));
    end
    in_valid   = 1'b0;
    in_sop     = 1'b0;
    in_eop     = 1'b0;
    out_ready2 = 1'b0;
    step();
    chk("rl2_valid_end", out_valid2, 0);
    chk("rl2_ferr_clean", ferr2, 0);

    // RL=3, out_ready pattern 1,0,1,1,0 then low
    pat = 10'b00000_01101;
    for (int c = 0; c < 10; c++) begin
      out_ready3 = (c < 5) ? pat[c] : 1'b0;
      in_valid   = 1'b1;
      in_data    = 32'h100 + 32'(c);
      if (c >= 3) begin
        chk($sformatf("rl3_valid_c%0d", c), out_valid3, pat[c-3]);
        if (pat[c-3]) chk($sformatf("rl3_data_c%0d", c), out_data3, 64'(32'h100 + 32'(c - 1)));
      end else begin
        chk($sformatf("rl3_valid_c%0d", c), out_valid3, 0);
      end
      step();
    end
    in_valid = 1'b0;

    // RL=1 clean packet with channel and error sideband
    out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      in_data    = 32'h200 + 32'(i);
      in_channel = 2'd2;
      in_error   = 6'h15;
      in_sop     = (i == 0);
      in_eop     = (i == 2);
      chk($sformatf("rl1_in_ready_%0d", i), in_ready1, 1);
      step();
      chk($sformatf("rl1_valid_%0d", i), out_valid1, 1);
      chk($sformatf("rl1_data_%0d", i), out_data1, 64'(32'h200 + 32'(i)));
      chk($sformatf("rl1_channel_%0d", i), out_channel1, 2);
      chk($sformatf("rl1_error_%0d", i), out_error1, 6'h15);
      chk($sformatf("rl1_sop_%0d", i), out_sop1, (i == 0));
      chk($sformatf("rl1_eop_%0d", i), out_eop1, (i == 2));
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    step();
    chk("rl1_ferr_clean", ferr1, 0);

    // Framing violations on RL=1
    in_valid = 1'b1;
    in_eop   = 1'b1;
    step();
    in_valid = 1'b0;
    in_eop   = 1'b0;
    chk("viol_eop_only", ferr1, 1);
    step();
    chk("viol_sticky", ferr1, 1);
    clear_error = 1'b1;
    step();
    clear_error = 1'b0;
    chk("viol_cleared", ferr1, 0);
    in_valid = 1'b1;
    in_sop   = 1'b1;
    step();
    chk("viol_first_sop", ferr1, 0);
    step();
    chk("viol_nested_sop", ferr1, 1);
    in_valid    = 1'b0;
    in_sop      = 1'b0;
    clear_error = 1'b1;
    step();
    chk("viol_cleared2", ferr1, 0);
    in_valid = 1'b1;
    in_sop   = 1'b1;
    step();
    chk("viol_wins_over_clear", ferr1, 1);
    clear_error = 1'b0;
    in_valid    = 1'b0;
    in_sop      = 1'b0;
    out_ready1  = 1'b0;

    // Reset mid-packet on RL=2
    out_ready2 = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 32'h2FF;
    step();
    chk("mid_outside_ferr", ferr2, 1);
    in_sop  = 1'b1;
    in_data = 32'h300;
    step();
    chk("mid_valid_before_rst", out_valid2, 1);
    chk("mid_data_before_rst", out_data2, 32'h300);
    in_sop  = 1'b0;
    in_data = 32'h301;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid2, 0);
    chk("mid_rst_ferr", ferr2, 0);
    chk("mid_rst_in_ready", in_ready2, 0);
    step();
    reset_n = 1'b1;
    chk("post_rst_in_ready", in_ready2, 0);
    step();
    chk("post_rst_valid0", out_valid2, 0);
    step();
    chk("post_rst_ferr", ferr2, 1);
    chk("post_rst_valid", out_valid2, 1);
    chk("post_rst_data", out_data2, 32'h301);

    // in_valid held while in_ready low: nothing transfers, payload holds
    in_valid   = 1'b0;
    out_ready2 = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_in_ready_%0d", i), in_ready2, 0);
      step();
      chk($sformatf("stall_valid_%0d", i), out_valid2, 0);
      chk($sformatf("stall_hold_%0d", i), out_data2, 32'h301);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
